apb_initiator_bridge: RTL and testbench

APB_INITIATOR_BRIDGE -- requirements
Module: apb_initiator_bridge

---
 rtl/apb_initiator_bridge.sv | 89 ++++++++
 tb/tb_apb_initiator_bridge.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_initiator_bridge.sv
// apb_initiator_bridge: command FIFO feeding an APB initiator, with a per-transfer wait timeout
module apb_initiator_bridge #(
    parameter int ADDRESSWIDTH = 3,
    parameter int DATAWIDTH    = 16,
    parameter int CMD_DEPTH    = 4,
    parameter int TIMEOUT      = 16
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic                    cmd_write_i,
    input  logic [ADDRESSWIDTH-1:0] cmd_addr_i,
    input  logic [DATAWIDTH-1:0]    cmd_wdata_i,
    output logic [ADDRESSWIDTH-1:0] PADDR_o,
    output logic [DATAWIDTH-1:0]    PWDATA_o,
    output logic                    PWRITE_o,
    output logic                    PSELx_o,
    output logic                    PENABLE_o,
    input  logic [DATAWIDTH-1:0]    PRDATA_i,
    input  logic                    PREADY_i,
    output logic                    rsp_valid_o,
    output logic [DATAWIDTH-1:0]    rsp_rdata_o,
    output logic                    rsp_err_o,
    output logic                    busy_o
);
    localparam int PW = $clog2(CMD_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = 1 + ADDRESSWIDTH + DATAWIDTH;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
    state_t state, nxt;
    logic [EW-1:0] mem [CMD_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [7:0] wait_cnt;
    logic push, pop, done, expire;
    logic head_write;
    logic [ADDRESSWIDTH-1:0] head_addr;
    logic [DATAWIDTH-1:0] head_wdata;
    assign {head_write, head_addr, head_wdata} = mem[rd_ptr];
    assign cmd_ready_o = count != CW'(CMD_DEPTH);
    assign busy_o = state != IDLE || count != '0;
    assign push = cmd_valid_i && cmd_ready_o;
    always_comb begin
        done = state == ACCESS && PREADY_i;
        expire = state == ACCESS && !PREADY_i && wait_cnt == 8'(TIMEOUT - 1);
        pop = count != '0 && (state == IDLE || done);
        nxt = pop ? SETUP : state == SETUP ? ACCESS : (done || expire) ? IDLE : state;
    end
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) state <= IDLE;
        else state <= nxt;
    end
    // Storage carries no reset; an entry is only read after it has been written.
    always_ff @(posedge PCLK) begin
        if (push) mem[wr_ptr] <= {cmd_write_i, cmd_addr_i, cmd_wdata_i};
    end
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            wait_cnt <= '0;
            PADDR_o <= '0;
            PWDATA_o <= '0;
            PWRITE_o <= 1'b0;
            PSELx_o <= 1'b0;
            PENABLE_o <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_err_o <= 1'b0;
            rsp_rdata_o <= '0;
        end else begin
            PSELx_o <= nxt != IDLE;
            PENABLE_o <= nxt == ACCESS;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
                PADDR_o <= head_addr;
                PWDATA_o <= head_wdata;
                PWRITE_o <= head_write;
            end
            count <= count + CW'(push) - CW'(pop);
            wait_cnt <= (state == ACCESS && !PREADY_i) ? wait_cnt + 8'd1 : 8'd0;
            rsp_valid_o <= done || expire;
            rsp_err_o <= expire;
            rsp_rdata_o <= (done && !PWRITE_o) ? PRDATA_i : '0;
        end
    end
endmodule

// File: tb/tb_apb_initiator_bridge.sv
// tb_apb_initiator_bridge: random command traffic against a transaction-level responder model,
// with a response scoreboard and directed latency, backpressure, timeout and reset scenarios.
module tb_apb_initiator_bridge;
    localparam int AW = 3;
    localparam int DW = 16;
    localparam int DEPTH = 4;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst_n;
    logic cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata, prdata = '0, rsp_rdata;
    logic pwrite, psel, penable, pready = 1'b0, rsp_valid, rsp_err, busy;

    always #5 clk = ~clk;

    apb_initiator_bridge #(.ADDRESSWIDTH(AW), .DATAWIDTH(DW), .CMD_DEPTH(DEPTH), .TIMEOUT(TO)) dut (
        .PCLK(clk), .PRESETn(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
        .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
        .PADDR_o(paddr), .PWDATA_o(pwdata), .PWRITE_o(pwrite), .PSELx_o(psel), .PENABLE_o(penable),
        .PRDATA_i(prdata), .PREADY_i(pready),
        .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err), .busy_o(busy)
    );

    typedef struct packed {logic w; logic [AW-1:0] a; logic [DW-1:0] d;} cmd_t;
    typedef struct packed {logic err; logic [DW-1:0] rdata;} rsp_t;
    cmd_t cmd_q[$];
    rsp_t exp_q[$];
    int checks = 0, errors = 0, accepted = 0, setups = 0;
    int force_w = -1, force_d = -1;
    bit in_acc = 0;
    int acc_cnt = 0, exp_cyc = 0, cur_w = 0;
    cmd_t cur;
    logic [DW-1:0] cur_data;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    // Responder: picks a wait count per transfer and derives the expected response from it.
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_acc && !(psel && penable)) begin
                chk("access_cycles", acc_cnt, exp_cyc);
                in_acc = 0;
            end
            if (psel && !penable) begin
                setups++;
                chk("setup_has_cmd", cmd_q.size() != 0, 1);
                if (cmd_q.size() != 0) cur = cmd_q.pop_front();
                chk("setup_paddr", paddr, cur.a);
                chk("setup_pwdata", pwdata, cur.d);
                chk("setup_pwrite", pwrite, cur.w);
                if (force_w >= 0) cur_w = force_w;
                else begin
                    case ($urandom_range(0, 9))
                        6: cur_w = TO - 1;
                        7: cur_w = TO;
                        8: cur_w = TO + 4;
                        default: cur_w = $urandom_range(0, 3);
                    endcase
                end
                cur_data = force_d >= 0 ? force_d[DW-1:0] : DW'($urandom);
                exp_q.push_back({cur_w >= TO, (cur_w >= TO || cur.w) ? '0 : cur_data});
                exp_cyc = cur_w >= TO ? TO : cur_w + 1;
                acc_cnt = 0;
                in_acc = 1;
                pready = 1'($urandom);
                prdata = DW'($urandom);
            end else if (psel && penable) begin
                chk("hold_paddr", paddr, cur.a);
                chk("hold_pwdata", pwdata, cur.d);
                chk("hold_pwrite", pwrite, cur.w);
                pready = acc_cnt == cur_w;
                prdata = pready ? cur_data : DW'($urandom);
                acc_cnt++;
            end else begin
                pready = 1'($urandom);
                prdata = DW'($urandom);
            end
            chk("cmd_ready", cmd_ready, (accepted - setups) < DEPTH);
            chk("busy", busy, (accepted - setups) > 0 || psel);
        end
    end

    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            rsp_t e;
            chk("rsp_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("rsp_err", rsp_err, e.err);
                chk("rsp_rdata", rsp_rdata, e.rdata);
            end
        end
    end

    task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int t = 0;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr = a;
        cmd_wdata = d;
        while (!cmd_ready && t < 500) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk("send_accepted", cmd_ready, 1);
        if (cmd_ready) begin
            cmd_q.push_back({w, a, d});
            accepted++;
            @(negedge clk);
            #1;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((cmd_q.size() != 0 || exp_q.size() != 0 || busy || in_acc) && t < 3000) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk("drain_done", cmd_q.size() != 0 || exp_q.size() != 0 || busy, 0);
    endtask

    initial begin
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwdata", pwdata, 0);
        chk("rst_pwrite", pwrite, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        #1;

        // Single write into an idle bridge: latency to SETUP, ACCESS and response.
        force_w = 0;
        send(1'b1, 3'd2, 16'h0001);
        chk("lat_psel_n", psel, 0);
        @(posedge clk);
        #1;
        chk("lat_psel_n1", psel, 1);
        chk("lat_penable_n1", penable, 0);
        @(posedge clk);
        #1;
        chk("lat_penable_n2", penable, 1);
        @(posedge clk);
        #1;
        chk("lat_rsp_n3", rsp_valid, 1);
        chk("lat_rsp_err", rsp_err, 0);
        chk("lat_rsp_rdata", rsp_rdata, 0);
        @(negedge clk);
        #1;
        drain();

        // Read with three wait states, fixed read data.
        force_w = 3;
        force_d = 16'h00A5;
        send(1'b0, 3'd4, 16'h1234);
        drain();
        force_d = -1;

        // Same address, alternating data, zero wait.
        force_w = 0;
        send(1'b1, 3'd1, 16'h00E0);
        send(1'b1, 3'd1, 16'h00F0);
        send(1'b1, 3'd1, 16'h00E0);
        drain();

        // Fill the FIFO behind a long transfer, then check back-to-back completion.
        force_w = TO - 1;
        for (int i = 1; i <= 5; i++) send(1'b1, 3'(i), 16'(i));
        chk("full_ready", cmd_ready, 0);
        for (int t = 0; t < 500; t++) begin
            @(negedge clk);
            #1;
            if (!(in_acc || cmd_q.size() != 0)) break;
            chk("psel_continuous", psel, 1);
        end
        drain();

        // Timeout abort.
        force_w = TO + 4;
        send(1'b0, 3'd3, 16'h0);
        drain();
        chk("timeout_idle", psel, 0);

        force_w = -1;
        for (int i = 0; i < 60; i++) begin
            send(1'($urandom), AW'($urandom), DW'($urandom));
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                #1;
            end
        end
        drain();

        // Reset during ACCESS with two commands still queued.
        force_w = TO - 1;
        for (int i = 0; i < 3; i++) send(1'b1, 3'(i), 16'(16'h100 + i));
        for (int t = 0; t < 50 && !(psel && penable); t++) begin
            @(negedge clk);
            #1;
        end
        chk("pre_reset_access", psel && penable, 1);
        chk("pre_reset_queued", accepted - setups, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_psel", psel, 0);
        chk("midrst_penable", penable, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_cmd_ready", cmd_ready, 1);
        cmd_q.delete();
        exp_q.delete();
        accepted = 0;
        setups = 0;
        in_acc = 0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        chk("post_reset_busy", busy, 0);
        chk("post_reset_psel", psel, 0);

        force_w = -1;
        for (int i = 0; i < 20; i++) send(1'($urandom), AW'($urandom), DW'($urandom));
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
